// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide unit with architectural HI/LO registers.
// One result bit per clock: WIDTH iterations plus one sign-fix cycle.
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   start, op         request (accepted when idle); 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   data1, data2      multiplicand/dividend, multiplier/divisor
//   cancel            flush: abort the operation in flight
//   hi_we, lo_we      MTHI/MTLO write enables (honoured only when idle)
//   wdata             MTHI/MTLO write data
//   busy, done        operation in flight; one-cycle result-written pulse
//   hi, lo            HI (product high / remainder), LO (product low / quotient)
module mult_div_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic             cancel,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic             div0_q, div0_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Operand entry: signed ops convert to magnitude and remember the signs
  logic             op_signed, sign1, sign2;
  logic [WIDTH-1:0] mag1, mag2;
  assign op_signed = ~op[0];
  assign sign1     = op_signed & data1[WIDTH-1];
  assign sign2     = op_signed & data2[WIDTH-1];
  assign mag1      = sign1 ? -data1 : data1;
  assign mag2      = sign2 ? -data2 : data2;

  // Shift-add step: add multiplicand when the multiplier LSB is set, then shift right
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);

  // Restoring divide step: shift in next dividend bit, subtract if it fits
  logic [WIDTH:0] div_shift, div_trial;
  assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, opnd_q};

  // Sign correction for the final writeback
  logic [PW-1:0]    prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  assign prod     = {acc_hi_q, acc_lo_q};
  assign prod_fix = neg_lo_q ? -prod : prod;
  assign quo_fix  = neg_lo_q ? -acc_lo_q : acc_lo_q;
  assign rem_fix  = neg_hi_q ? -acc_hi_q : acc_hi_q;

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    div0_d   = div0_q;
    opnd_d   = opnd_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start && !cancel) begin
          state_d  = S_CALC;
          cnt_d    = '0;
          is_div_d = op[1];
          neg_lo_d = sign1 ^ sign2;
          neg_hi_d = sign1;
          div0_d   = op[1] && (data2 == '0);
          opnd_d   = op[1] ? mag2 : mag1;
          acc_hi_d = '0;
          acc_lo_d = op[1] ? mag1 : mag2;
        end
      end
      S_CALC: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else begin
          if (is_div_q) begin
            acc_hi_d = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], ~div_trial[WIDTH]};
          end else begin
            acc_hi_d = mul_sum[WIDTH:1];
            acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!cancel) begin
          done_d = 1'b1;
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = div0_q ? '1 : quo_fix;
          end else begin
            hi_d = prod_fix[PW-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      div0_q   <= 1'b0;
      opnd_q   <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      div0_q   <= div0_d;
      opnd_q   <= opnd_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
